// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions.
//   NK, NR           : key length in words / number of rounds
//   block_t, word_t  : 128-bit state/key block and 32-bit word types
//   ks_state_t       : key schedule controller states
//   rcon(rnd)        : round constant byte for rounds 1..10, 0 otherwise
//   sbox(b)          : forward AES S-box, also used by the round datapath
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = 10;

  typedef logic [127:0] block_t;
  typedef logic [31:0]  word_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } ks_state_t;

  // Forward S-box, entry 0x00 in the top byte and entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] value;
    case (rnd)
      4'd1:    value = 8'h01;
      4'd2:    value = 8'h02;
      4'd3:    value = 8'h04;
      4'd4:    value = 8'h08;
      4'd5:    value = 8'h10;
      4'd6:    value = 8'h20;
      4'd7:    value = 8'h40;
      4'd8:    value = 8'h80;
      4'd9:    value = 8'h1b;
      4'd10:   value = 8'h36;
      default: value = 8'h00;
    endcase
    return value;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/sub_word.sv
// sub_word: AES SubWord, four parallel combinational S-box lookups.
//   data   : 32-bit input word
//   result : each byte of data replaced by its S-box image
module sub_word
  import aes_pkg::*;
(
  input  word_t data,
  output word_t result
);

  assign result = {sbox(data[31:24]), sbox(data[23:16]),
                   sbox(data[15:8]),  sbox(data[7:0])};

endmodule

// File: rtl/key_expansion.sv
// key_expansion: iterative AES-128 key schedule.
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   en             : global stall, all state freezes while low
//   key_valid_i    : key_i carries a cipher key to load
//   key_i          : cipher key, byte 0 at [127:120]
//   key_ready_o    : a key can be accepted this cycle (IDLE and en)
//   keys_valid_o   : all 11 round keys are complete and stable
//   round_keys_o   : round key r at [128*r +: 128], r = 0..10
module key_expansion
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           key_valid_i,
  input  logic [127:0]   key_i,
  output logic           key_ready_o,
  output logic           keys_valid_o,
  output logic [1407:0]  round_keys_o
);

  ks_state_t state;
  logic [3:0] rnd;
  block_t     rk [NR+1];

  block_t prev_key;
  block_t next_key;
  word_t  sub_out;
  word_t  w0, w1, w2, w3;
  word_t  n0, n1, n2, n3;

  // Select RK[rnd-1] with an explicit compare so rnd = 0 never forms an
  // out-of-range index.
  always_comb begin
    prev_key = '0;
    for (int i = 0; i < NR; i++) begin
      if (rnd == 4'(i + 1)) prev_key = rk[i];
    end
  end

  assign {w0, w1, w2, w3} = prev_key;

  sub_word u_sub_word (
    .data   ({w3[23:0], w3[31:24]}),
    .result (sub_out)
  );

  assign n0 = w0 ^ sub_out ^ {rcon(rnd), 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  assign key_ready_o = (state == IDLE) && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rnd          <= 4'd0;
      keys_valid_o <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (key_valid_i) begin
            rk[0]        <= key_i;
            rnd          <= 4'd1;
            keys_valid_o <= 1'b0;
            state        <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= NR; i++) begin
            if (rnd == 4'(i)) rk[i] <= next_key;
          end
          if (rnd == 4'(NR)) begin
            keys_valid_o <= 1'b1;
            rnd          <= 4'd0;
            state        <= IDLE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r <= NR; r++) begin : g_flat
    assign round_keys_o[128*r +: 128] = rk[r];
  end

endmodule
